// File: rtl/sseg_pkg.sv
// Shared constants and helpers for seven-segment display drivers.
// Segment patterns are active-low (0 = segment lit), with segment a in the MSB.
package sseg_pkg;

    localparam int MAX_DIGITS = 32;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b0000001;
    localparam logic [6:0] SEG_ONE   = 7'b1001111;
    localparam logic [6:0] SEG_TWO   = 7'b0010010;
    localparam logic [6:0] SEG_THREE = 7'b0000110;
    localparam logic [6:0] SEG_FOUR  = 7'b1001100;
    localparam logic [6:0] SEG_FIVE  = 7'b0100100;
    localparam logic [6:0] SEG_SIX   = 7'b0100000;
    localparam logic [6:0] SEG_SEVEN = 7'b0001111;
    localparam logic [6:0] SEG_EIGHT = 7'b0000000;
    localparam logic [6:0] SEG_NINE  = 7'b0001100;

    // One-cold anode vector: bit idx low when idx < n, every other bit high.
    function automatic logic [MAX_DIGITS-1:0] idx_to_anode(input int unsigned idx,
                                                           input int unsigned n);
        logic [MAX_DIGITS-1:0] v;
        v = '1;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if ((i == idx) && (i < n))
                v[i] = 1'b0;
        end
        return v;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle tick every PRESCALE cycles; PRESCALE=1 ticks every clk.
// Tick is a combinational decode of the registered count; no backpressure.
module tick_prescaler #(
    parameter int PRESCALE = 100000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed seven-segment scanner with per-digit blanking, dp mask and PWM brightness.
// Pins are registered 1 clk after digit_idx/input changes; free-running, no backpressure.
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SEG_W      = 7,
    parameter int PRESCALE   = 100000,
    parameter int BRIGHT_W   = 3,
    localparam int IDX_W     = $clog2(NUM_DIGITS)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]       dp_mask,
    input  logic [NUM_DIGITS-1:0]       digit_en,
    input  logic [BRIGHT_W-1:0]         brightness,
    output logic [SEG_W-1:0]            sseg,
    output logic [NUM_DIGITS-1:0]       an,
    output logic                        dp,
    output logic [IDX_W-1:0]            digit_idx,
    output logic                        frame_tick
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic                  slot_tick;
    logic [BRIGHT_W-1:0]   pwm_cnt;
    logic                  on_phase;
    logic                  digit_on;
    logic                  idx_wrap;
    logic [NUM_DIGITS-1:0] anode_vec;
    logic [SEG_W-1:0]      seg_arr [NUM_DIGITS];

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (slot_tick)
    );

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slice
        assign seg_arr[g] = seg_in[g*SEG_W +: SEG_W];
    end

    // Explicit wrap keeps non-power-of-2 digit counts from aliasing.
    assign idx_wrap  = (digit_idx == IDX_LAST);
    assign on_phase  = (pwm_cnt <= brightness);
    assign digit_on  = digit_en[digit_idx] & on_phase;
    assign anode_vec = NUM_DIGITS'(idx_to_anode(32'(digit_idx), NUM_DIGITS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_idx  <= '0;
            frame_tick <= 1'b0;
            pwm_cnt    <= '0;
        end else begin
            pwm_cnt    <= pwm_cnt + 1'b1;
            frame_tick <= slot_tick & idx_wrap;
            if (slot_tick)
                digit_idx <= idx_wrap ? '0 : digit_idx + 1'b1;
        end
    end

    // Inputs are sampled live every clk so updates reach the pins with 1-clk latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an   <= '1;
            sseg <= '1;
            dp   <= 1'b1;
        end else if (digit_on) begin
            an   <= anode_vec;
            sseg <= seg_arr[digit_idx];
            dp   <= ~dp_mask[digit_idx];
        end else begin
            an   <= '1;
            sseg <= '1;
            dp   <= 1'b1;
        end
    end

    a_one_anode: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(~an));

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux across three configurations.
// Instances: A = 4 digits/PRESCALE 1, B = 6 digits/PRESCALE 3, C = 4 digits/PRESCALE 16.
module tb_sseg_scan_mux;
    import sseg_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [6:0]  pat [4];
    logic [27:0] seg4;
    logic [3:0]  dp4;
    logic [3:0]  en4;
    logic [2:0]  bright;
    logic [41:0] seg6;
    logic [5:0]  dp6;
    logic [5:0]  en6;

    assign seg4 = {pat[3], pat[2], pat[1], pat[0]};

    logic [6:0] a_sseg, b_sseg, c_sseg;
    logic [3:0] a_an, c_an;
    logic [5:0] b_an;
    logic       a_dp, b_dp, c_dp;
    logic [1:0] a_idx, c_idx;
    logic [2:0] b_idx;
    logic       a_ft, b_ft, c_ft;

    sseg_scan_mux #(.NUM_DIGITS(4), .SEG_W(7), .PRESCALE(1), .BRIGHT_W(3)) u_a (
        .clk(clk), .reset_n(reset_n), .seg_in(seg4), .dp_mask(dp4), .digit_en(en4),
        .brightness(bright), .sseg(a_sseg), .an(a_an), .dp(a_dp), .digit_idx(a_idx),
        .frame_tick(a_ft));

    sseg_scan_mux #(.NUM_DIGITS(6), .SEG_W(7), .PRESCALE(3), .BRIGHT_W(3)) u_b (
        .clk(clk), .reset_n(reset_n), .seg_in(seg6), .dp_mask(dp6), .digit_en(en6),
        .brightness(bright), .sseg(b_sseg), .an(b_an), .dp(b_dp), .digit_idx(b_idx),
        .frame_tick(b_ft));

    sseg_scan_mux #(.NUM_DIGITS(4), .SEG_W(7), .PRESCALE(16), .BRIGHT_W(3)) u_c (
        .clk(clk), .reset_n(reset_n), .seg_in(seg4), .dp_mask(dp4), .digit_en(en4),
        .brightness(bright), .sseg(c_sseg), .an(c_an), .dp(c_dp), .digit_idx(c_idx),
        .frame_tick(c_ft));

    task automatic apply_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #23;
        n_chk++;
        if ({a_an, a_sseg, a_dp, a_ft, a_idx} !== {4'hF, 7'h7F, 1'b1, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_a got an=%b sseg=%b dp=%b ft=%b idx=%0d want an=1111 sseg=1111111 dp=1 ft=0 idx=0",
                     a_an, a_sseg, a_dp, a_ft, a_idx);
        end
        n_chk++;
        if ({b_an, b_sseg, b_dp, b_ft, b_idx} !== {6'h3F, 7'h7F, 1'b1, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_b got an=%b sseg=%b dp=%b ft=%b idx=%0d", b_an, b_sseg, b_dp, b_ft, b_idx);
        end
        n_chk++;
        if ({c_an, c_sseg, c_dp, c_ft, c_idx} !== {4'hF, 7'h7F, 1'b1, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_c got an=%b sseg=%b dp=%b ft=%b idx=%0d", c_an, c_sseg, c_dp, c_ft, c_idx);
        end
    endtask

    task automatic test_scan();
        logic [3:0] e_an;
        bright = 3'd7; en4 = 4'hF; dp4 = 4'h0;
        apply_reset();
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            e_an = ~(4'b0001 << ((k - 1) % 4));
            n_chk++;
            if (a_an !== e_an) begin
                n_fail++;
                $display("FAIL scan_an k=%0d got %b want %b", k, a_an, e_an);
            end
            n_chk++;
            if (a_sseg !== pat[(k - 1) % 4] || a_dp !== 1'b1) begin
                n_fail++;
                $display("FAIL scan_seg k=%0d got %b/%b want %b/1", k, a_sseg, a_dp, pat[(k - 1) % 4]);
            end
            n_chk++;
            if (a_ft !== (k % 4 == 0)) begin
                n_fail++;
                $display("FAIL scan_frame k=%0d got %b want %b", k, a_ft, (k % 4 == 0));
            end
            n_chk++;
            if (a_idx !== 2'(k % 4)) begin
                n_fail++;
                $display("FAIL scan_idx k=%0d got %0d want %0d", k, a_idx, k % 4);
            end
        end
    endtask

    task automatic test_wrap6();
        logic [5:0] e_an;
        bright = 3'd7; en6 = 6'h3F; dp6 = 6'h00;
        apply_reset();
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            e_an = ~(6'b000001 << (((k - 1) / 3) % 6));
            n_chk++;
            if (b_idx !== 3'((k / 3) % 6)) begin
                n_fail++;
                $display("FAIL wrap_idx k=%0d got %0d want %0d", k, b_idx, (k / 3) % 6);
            end
            n_chk++;
            if (b_ft !== (k % 18 == 0)) begin
                n_fail++;
                $display("FAIL wrap_frame k=%0d got %b want %b", k, b_ft, (k % 18 == 0));
            end
            n_chk++;
            if (b_an !== e_an) begin
                n_fail++;
                $display("FAIL wrap_an k=%0d got %b want %b", k, b_an, e_an);
            end
        end
    endtask

    task automatic test_blank_dp();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int d;
        bright = 3'd7; en4 = 4'b1011; dp4 = 4'b0100;
        apply_reset();
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            d = ((k - 1) / 16) % 4;
            if (d == 2) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an = ~(4'b0001 << d); e_seg = pat[d]; e_dp = 1'b1;
            end
            n_chk++;
            if (c_an !== e_an || c_sseg !== e_seg || c_dp !== e_dp) begin
                n_fail++;
                $display("FAIL blank_dp k=%0d got an=%b sseg=%b dp=%b want an=%b sseg=%b dp=%b",
                         k, c_an, c_sseg, c_dp, e_an, e_seg, e_dp);
            end
        end
        // Enable digit 2 so its lit decimal point becomes visible.
        en4 = 4'b1111;
        apply_reset();
        for (int k = 1; k <= 48; k++) begin
            @(posedge clk); #1;
        end
        n_chk++;
        if (c_an !== 4'b1011 || c_sseg !== SEG_NINE || c_dp !== 1'b0) begin
            n_fail++;
            $display("FAIL dp_digit2 got an=%b sseg=%b dp=%b want an=1011 sseg=%b dp=0",
                     c_an, c_sseg, c_dp, SEG_NINE);
        end
        dp4 = 4'h0;
    endtask

    task automatic test_brightness();
        int cnt;
        en4 = 4'hF; dp4 = 4'h0; bright = 3'd1;
        apply_reset();
        for (int s = 0; s < 4; s++) begin
            cnt = 0;
            for (int j = 0; j < 16; j++) begin
                @(posedge clk); #1;
                if (c_an !== 4'hF) cnt++;
            end
            n_chk++;
            if (cnt != 4) begin
                n_fail++;
                $display("FAIL bright1 slot=%0d got %0d lit clks want 4", s, cnt);
            end
        end
        bright = 3'd7;
        apply_reset();
        for (int s = 0; s < 2; s++) begin
            cnt = 0;
            for (int j = 0; j < 16; j++) begin
                @(posedge clk); #1;
                if (c_an !== 4'hF) cnt++;
            end
            n_chk++;
            if (cnt != 16) begin
                n_fail++;
                $display("FAIL bright7 slot=%0d got %0d lit clks want 16", s, cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e_an;
        bright = 3'd7; en4 = 4'hF; dp4 = 4'h0;
        apply_reset();
        for (int k = 1; k <= 39; k++) begin
            @(posedge clk);
        end
        #1;
        n_chk++;
        if (c_an !== 4'b1011) begin
            n_fail++;
            $display("FAIL mid_pre got an=%b want 1011", c_an);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_chk++;
        if ({c_an, c_sseg, c_dp, c_ft, c_idx} !== {4'hF, 7'h7F, 1'b1, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL mid_async got an=%b sseg=%b dp=%b ft=%b idx=%0d want 1111/1111111/1/0/0",
                     c_an, c_sseg, c_dp, c_ft, c_idx);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            e_an = (k <= 16) ? 4'b1110 : 4'b1101;
            n_chk++;
            if (c_an !== e_an) begin
                n_fail++;
                $display("FAIL mid_after k=%0d got %b want %b", k, c_an, e_an);
            end
        end
    endtask

    task automatic test_live();
        bright = 3'd7; en4 = 4'hF; dp4 = 4'h0; pat[0] = SEG_ZERO;
        apply_reset();
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
        end
        #1;
        n_chk++;
        if (c_sseg !== SEG_ZERO) begin
            n_fail++;
            $display("FAIL live_before got %b want %b", c_sseg, SEG_ZERO);
        end
        @(negedge clk);
        pat[0] = SEG_NINE;
        @(posedge clk); #1;
        n_chk++;
        if (c_sseg !== SEG_NINE || c_an !== 4'b1110) begin
            n_fail++;
            $display("FAIL live_after got sseg=%b an=%b want sseg=%b an=1110", c_sseg, c_an, SEG_NINE);
        end
        pat[0] = SEG_ZERO;
    endtask

    initial begin
        pat[0] = SEG_ZERO; pat[1] = SEG_ONE; pat[2] = SEG_NINE; pat[3] = SEG_THREE;
        dp4 = 4'h0; en4 = 4'hF; bright = 3'd7;
        seg6 = {SEG_FIVE, SEG_FOUR, SEG_THREE, SEG_TWO, SEG_ONE, SEG_ZERO};
        dp6 = 6'h00; en6 = 6'h3F;
        test_reset();
        test_scan();
        test_wrap6();
        test_blank_dp();
        test_brightness();
        test_reset_mid();
        test_live();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sseg_scan_mux.md
Name: sseg_scan_mux

Overview:
Parametrised time-multiplexed seven-segment display driver, successor to the fixed 4-digit scan mux. It scans NUM_DIGITS digits at a programmable refresh rate and adds per-digit blanking, a programmable decimal-point mask and PWM brightness control. It sits between the digit/segment encoders and the board's anode/cathode pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (≥2, need not be a power of 2)
SEG_W, 7, segment bits per digit (active-low cathodes)
PRESCALE, 100000, clk cycles per digit slot (≥1; 1 = advance every clk)
BRIGHT_W, 3, brightness control width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
seg_in  in  NUM_DIGITS*SEG_W  packed segment patterns; digit i = seg_in[i*SEG_W +: SEG_W]
dp_mask  in  NUM_DIGITS  1 = decimal point lit on digit i
digit_en  in  NUM_DIGITS  1 = digit i displayed, 0 = blanked
brightness  in  BRIGHT_W  duty level; 0 = minimum, all-ones = full on
sseg  out  SEG_W  active-low segment drive (registered)
an  out  NUM_DIGITS  active-low one-cold anode drive (registered)
dp  out  1  active-low decimal point (registered)
digit_idx  out  clog2(NUM_DIGITS)  index of digit currently scanned
frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset (reset_n low, asynchronous): prescaler=0, digit_idx=0, pwm counter=0, an=all ones, sseg=all ones, dp=1, frame_tick=0. Deassertion is synchronised externally; the first active edge starts counting from 0.
- Prescaler: counts 0..PRESCALE-1. slot_tick asserts on the cycle count==PRESCALE-1, then the count wraps to 0.
- Digit index: on slot_tick, digit_idx <= (digit_idx==NUM_DIGITS-1) ? 0 : digit_idx+1. Explicit wrap; no modulo-2^n aliasing for non-power-of-2 counts such as 6.
- frame_tick: registered. High for exactly one cycle, the cycle in which digit_idx becomes 0 via wrap. Never asserted at reset exit.
- PWM: free-running BRIGHT_W-bit counter incrementing every clk. on_phase = (pwm_cnt <= brightness). Full-scale brightness gives 100% duty; 0 gives 1/2^BRIGHT_W duty.
- Output stage: registered every clk from current digit_idx and live inputs (no input latching). Latency is 1 clk from a digit_idx change or input change to the pins.
  - Digit displayed (digit_en[idx]=1 and on_phase=1): an = ~(1<<idx), sseg = seg_in slice idx, dp = ~dp_mask[idx].
  - Digit off (digit_en[idx]=0 or on_phase=0): an = all ones, sseg = all ones, dp = 1.
- A blanked digit still consumes its full slot, so refresh timing is independent of digit_en.
- Exactly one anode low at most, in any cycle.
- Simultaneous events: an input change on the slot_tick cycle uses the new idx and new inputs in the following registered output.
- Reset mid-slot: immediate return to reset values. The partial slot is discarded.
- PRESCALE=1 reproduces the legacy behaviour: advance every clk, digit 0 first.

Decomposition:
- Package sseg_pkg holds:
  - SEG_BLANK constant (all ones).
  - Active-low digit constants (e.g. SEG_ZERO = 7'b0000001, SEG_NINE = 7'b0001100) for benches and encoders.
  - Function idx_to_anode(idx, n) returning the one-cold vector.
- Sub-module tick_prescaler (parameter PRESCALE; ports clk, reset_n, tick) generates slot_tick. It is reusable by other timing blocks.

Test Plan:
- Reset and scan: NUM_DIGITS=4, PRESCALE=1, all enabled, brightness=7 -> an cycles 1110,1101,1011,0111 on consecutive clks (1-clk latency after reset release); frame_tick pulses every 4 clks.
- Non-power-of-2 wrap: NUM_DIGITS=6, PRESCALE=3 -> digit_idx runs 0..5 changing every 3 clks, then 0; frame_tick period is 18 clks; an never shows an invalid pattern.
- Blanking and dp: digit_en=4'b1011, dp_mask=4'b0100, seg_in digit2=SEG_NINE -> slot 2 has an=all ones, sseg=all ones, dp=1; slot 1 shows its pattern with dp=1; no other digit shows dp=0.
- Brightness: BRIGHT_W=3, brightness=1, PRESCALE=16 -> within each 16-clk slot, an is low for exactly 4 clks (2 of every 8); brightness=7 -> low for all 16.
- Async reset mid-slot: assert reset_n low at prescaler=7 of digit 2 -> outputs go to reset values without waiting for clk; after release, digit 0 is shown for a full PRESCALE slot.
- Live input update: change seg_in digit0 from SEG_ZERO to SEG_NINE while digit 0 is active -> sseg shows SEG_NINE on the next clk.
